regfile_write_port: RTL

- Write side of the 32 x 64-bit integer register file.
- Takes write-back requests from the pipeline over a valid/ready handshake and buffers them in a small in-order queue.
- Decodes the 5-bit destination to a one-hot enable, commits one write per cycle, and drives every register on a flat bus.
- The existing 32-to-1 read muxes select read operands from that flat bus. X31 (XZR) always reads zero.

---
 rtl/regfile_write_port_pkg.sv | 9 +
 rtl/write_decoder_5to32.sv | 17 +
 rtl/regfile_write_port.sv | 119 +++++++++++
 3 files changed

// File: rtl/regfile_write_port_pkg.sv
// Shared constants for the integer register file write side.
// Register 31 is the zero register and is never written.
package regfile_write_port_pkg;

  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] XZR_ADDR = 5'd31;

endpackage

// File: rtl/write_decoder_5to32.sv
// 5-to-32 one-hot write-enable decoder.
// Bit 31 (the zero register) is never enabled.
module write_decoder_5to32
  import regfile_write_port_pkg::*;
(
  input  logic                  en_i,
  input  logic [REG_ADDR_W-1:0] addr_i,
  output logic [NUM_REGS-1:0]   onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[addr_i] = 1'b1;
    onehot_o[XZR_ADDR] = 1'b0;
  end

endmodule

// File: rtl/regfile_write_port.sv
// Write side of the 32 x N register file: in-order write
// queue, one commit per cycle, flat register output bus.
module regfile_write_port
  import regfile_write_port_pkg::*;
#(
  parameter int N     = 64,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [N-1:0]          wr_data,
  input  logic                  hold,
  input  logic                  flush,
  output logic [2:0]            q_count,
  output logic [NUM_REGS-1:0]   pend_mask,
  output logic [NUM_REGS*N-1:0] reg_flat
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [2:0] DEPTH_C = 3'(DEPTH);

  logic [REG_ADDR_W-1:0] addr_q [DEPTH];
  logic [N-1:0]          data_q [DEPTH];
  logic [DEPTH-1:0]      vld_q, vld_d;
  logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q;
  logic [2:0]            cnt_q, cnt_d;
  logic [NUM_REGS-1:0]   pend_q, pend_d;
  logic [N-1:0]          regs_q [NUM_REGS-1];

  logic                  accept, enq, commit;
  logic [REG_ADDR_W-1:0] head_addr;
  logic [N-1:0]          head_data;
  logic [NUM_REGS-1:0]   dec;
  logic                  dec_unused;

  assign wr_ready = reset_n && !flush &&
                    (cnt_q < DEPTH_C || !hold);
  assign accept   = wr_valid && wr_ready;
  assign enq      = accept && (wr_addr != XZR_ADDR);
  assign commit   = !hold && !flush && (cnt_q != 3'd0);

  assign head_addr = addr_q[rd_ptr_q];
  assign head_data = data_q[rd_ptr_q];

  write_decoder_5to32 u_dec (
    .en_i     (commit),
    .addr_i   (head_addr),
    .onehot_o (dec)
  );

  assign dec_unused = dec[NUM_REGS-1];

  always_comb begin
    logic [REG_ADDR_W-1:0] a;
    vld_d  = vld_q;
    pend_d = '0;
    if (commit) vld_d[rd_ptr_q] = 1'b0;
    if (enq)    vld_d[wr_ptr_q] = 1'b1;
    if (flush)  vld_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      a = addr_q[i];
      if (enq && wr_ptr_q == PTR_W'(i)) a = wr_addr;
      if (vld_d[i]) pend_d[a] = 1'b1;
    end
  end

  always_comb begin
    if (flush)                cnt_d = 3'd0;
    else if (enq && !commit)  cnt_d = cnt_q + 3'd1;
    else if (!enq && commit)  cnt_d = cnt_q - 3'd1;
    else                      cnt_d = cnt_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q    <= '0;
      cnt_q    <= '0;
      pend_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      for (int r = 0; r < NUM_REGS-1; r++)
        regs_q[r] <= '0;
    end else begin
      vld_q  <= vld_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (commit) rd_ptr_q <= rd_ptr_q + 1'b1;
        if (enq) begin
          addr_q[wr_ptr_q] <= wr_addr;
          data_q[wr_ptr_q] <= wr_data;
          wr_ptr_q         <= wr_ptr_q + 1'b1;
        end
      end
      for (int r = 0; r < NUM_REGS-1; r++)
        if (dec[r]) regs_q[r] <= head_data;
    end
  end

  assign q_count   = cnt_q;
  assign pend_mask = pend_q;

  always_comb begin
    reg_flat = '0;
    for (int r = 0; r < NUM_REGS-1; r++)
      reg_flat[r*N +: N] = regs_q[r];
  end

endmodule
